// File: rtl/wddl_pkg.sv
// Shared types and constants for the WDDL dual-rail output boundary.
package wddl_pkg;

    typedef enum logic [2:0] {
        ST_PRE,
        ST_SETTLE,
        ST_CHECK,
        ST_HOLD,
        ST_DRAIN
    } dr_state_e;

    localparam logic PH_PRECHARGE = 1'b0;
    localparam logic PH_EVAL      = 1'b1;
    localparam int   WDDL_W       = 128;

    // Counter must reach max(a,b)-1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/wddl_rail_check.sv
// Combinational reductions over a W-bit true/false rail pair.
module wddl_rail_check #(
    parameter int W = 128
) (
    input  logic [W-1:0] rail_t,
    input  logic [W-1:0] rail_f,
    output logic         zero,
    output logic         complete,
    output logic         conflict
);

    assign zero     = ~|(rail_t | rail_f);
    assign complete = &(rail_t ^ rail_f);
    assign conflict = |(rail_t & rail_f);

endmodule

// File: rtl/wddl_dr_decoder.sv
// Dual-rail to single-ended decoder with precharge/evaluate checking
// and a valid/ready handoff of the decoded word.
module wddl_dr_decoder
    import wddl_pkg::*;
#(
    parameter int W      = WDDL_W,
    parameter int SETTLE = 2,
    parameter int TMO    = 15
) (
    input  logic         CK,
    input  logic         RN,
    input  logic         eval,
    input  logic [W-1:0] din_t,
    input  logic [W-1:0] din_f,
    output logic [W-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         busy,
    output logic         err_pre,
    output logic         err_eval,
    input  logic         err_clr
);

    localparam int CW = cnt_width(SETTLE, TMO);
    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

    logic          eval_q;
    logic [W-1:0]  dt_q;
    logic [W-1:0]  df_q;
    logic          zero;
    logic          complete;
    logic          conflict;
    logic          pz;
    logic [CW-1:0] cnt;
    dr_state_e     state;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            eval_q <= PH_PRECHARGE;
            dt_q   <= '0;
            df_q   <= '0;
        end else begin
            eval_q <= eval;
            dt_q   <= din_t;
            df_q   <= din_f;
        end
    end

    wddl_rail_check #(.W(W)) u_rail_check (
        .rail_t   (dt_q),
        .rail_f   (df_q),
        .zero     (zero),
        .complete (complete),
        .conflict (conflict)
    );

    assign busy = (state != ST_PRE);

    // Error sets are written after the clear so a same-cycle set wins.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state      <= ST_PRE;
            pz         <= 1'b1;
            cnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            err_pre    <= 1'b0;
            err_eval   <= 1'b0;
        end else begin
            if (err_clr) begin
                err_pre  <= 1'b0;
                err_eval <= 1'b0;
            end
            unique case (state)
                ST_PRE: begin
                    if (eval_q == PH_EVAL) begin
                        state <= ST_SETTLE;
                        cnt   <= '0;
                        if (!pz) err_pre <= 1'b1;
                    end else begin
                        pz <= zero;
                    end
                end
                ST_SETTLE: begin
                    if (eval_q == PH_PRECHARGE) begin
                        err_eval <= 1'b1;
                        state    <= ST_PRE;
                    end else if (cnt == SET_LAST) begin
                        state <= ST_CHECK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (eval_q == PH_PRECHARGE) begin
                        err_eval <= 1'b1;
                        state    <= ST_PRE;
                    end else if (conflict) begin
                        err_eval <= 1'b1;
                        state    <= ST_DRAIN;
                    end else if (complete) begin
                        dout       <= dt_q;
                        dout_valid <= 1'b1;
                        state      <= ST_HOLD;
                    end else if (cnt == TMO_LAST) begin
                        err_eval <= 1'b1;
                        state    <= ST_DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (dout_ready) begin
                        dout_valid <= 1'b0;
                        state      <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (eval_q == PH_PRECHARGE) state <= ST_PRE;
                end
                default: state <= ST_PRE;
            endcase
        end
    end

endmodule
